// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU table-write path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ppu_pkg;

    localparam logic [9:0]  VACTIVE     = 10'd480;
    localparam logic [15:0] COMMIT_ADDR = 16'hFFFF;

    // Table select lives in address[15:12]; 3 and above are all sprite tables.
    localparam logic [3:0] TBL_ATTR    = 4'h0;
    localparam logic [3:0] TBL_COLOR   = 4'h1;
    localparam logic [3:0] TBL_PATTERN = 4'h2;
    localparam logic [3:0] TBL_SPRITE  = 4'h3;

    typedef enum logic [1:0] {
        Q_IDLE  = 2'd0,
        Q_ARMED = 2'd1,
        Q_DRAIN = 2'd2
    } queue_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] dat;
    } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead head and occupancy count.
// Latency: push visible at head/count the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 256,
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vblank_write_queue.sv
// Holds CPU table writes until software commits and the raster enters vblank.
// Latency: first ppu write two cycles after vblank is sampled, then one per cycle.
// Backpressure: waitrequest when FIFO full, or on a commit while one is pending.
module vblank_write_queue #(
    parameter int          DEPTH       = 256,
    parameter int          PTR_W       = 8,
    parameter logic [9:0]  VACTIVE     = ppu_pkg::VACTIVE,
    parameter logic [15:0] COMMIT_ADDR = ppu_pkg::COMMIT_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write,
    input  logic [15:0]      address,
    input  logic [31:0]      writedata,
    output logic             waitrequest,
    input  logic [9:0]       vcount,
    output logic             ppu_chipselect,
    output logic             ppu_write,
    output logic [15:0]      ppu_address,
    output logic [31:0]      ppu_writedata,
    output logic [PTR_W:0]   fifo_count,
    output logic             armed
);

    import ppu_pkg::*;

    queue_state_t state;
    queue_state_t state_nxt;

    logic           vblank;
    logic           wr_req;
    logic           is_commit;
    logic           accept;
    logic           push;
    logic           pop;
    logic           commit_go;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PTR_W:0] remaining;
    wr_entry_t      push_entry;
    wr_entry_t      head_entry;

    assign vblank    = (vcount >= VACTIVE);
    assign wr_req    = chipselect & write;
    assign is_commit = (address == COMMIT_ADDR);

    // A commit stalls while the previous one is still being released.
    assign waitrequest = wr_req & ((~is_commit & fifo_full) |
                                   ( is_commit & (state != Q_IDLE)));
    assign accept      = wr_req & ~waitrequest;
    assign push        = accept & ~is_commit;
    assign commit_go   = accept & is_commit & (state == Q_IDLE) & (fifo_count != '0);

    assign push_entry.addr = address;
    assign push_entry.dat  = writedata;

    sync_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= Q_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            Q_IDLE: begin
                if (commit_go)
                    state_nxt = Q_ARMED;
            end
            Q_ARMED: begin
                if (vblank)
                    state_nxt = Q_DRAIN;
            end
            Q_DRAIN: begin
                if (!vblank)
                    state_nxt = Q_ARMED;
                else if (remaining == (PTR_W+1)'(1))
                    state_nxt = Q_IDLE;
            end
            default: state_nxt = Q_IDLE;
        endcase
    end

    always_comb begin
        armed = (state != Q_IDLE);
        pop   = (state == Q_DRAIN) & vblank & (remaining != '0) & ~fifo_empty;
    end

    // Only entries present at commit time are released; later pushes wait.
    always_ff @(posedge clk) begin
        if (!reset)
            remaining <= '0;
        else if (commit_go)
            remaining <= fifo_count;
        else if (pop)
            remaining <= remaining - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ppu_chipselect <= 1'b0;
            ppu_write      <= 1'b0;
            ppu_address    <= '0;
            ppu_writedata  <= '0;
        end else begin
            ppu_chipselect <= pop;
            ppu_write      <= pop;
            ppu_address    <= pop ? head_entry.addr : 16'h0;
            ppu_writedata  <= pop ? head_entry.dat  : 32'h0;
        end
    end

endmodule
